mem_bus_if: RTL and testbench

- Data-bus master for the MEM stage. Converts the MEM stage's single-cycle load/store request into a Wishbone-style cyc/stb/ack transaction.
- Raises a stall request while the access is outstanding.
- Holds load data until the pipeline releases, so the mem→mem_wb register receives valid data on the cycle MEM advances.
- Sits between the MEM stage (upstream) and the data memory/bus (downstream). Its stall request feeds the pipeline stall controller.

---
 rtl/mem_bus_if.sv | 156 +++++++++++++++
 tb/tb_mem_bus_if.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage data-bus master.
// Turns a single-cycle load/store request into a cyc/stb/ack bus transfer,
// stalls the pipeline while the transfer is outstanding, and holds load data
// until the pipeline releases so the mem->mem_wb register captures it.
module mem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                bus_cyc_q, bus_cyc_d;
  logic                bus_stb_q, bus_stb_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0]   bus_data_q, bus_data_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;

  // Next-state and registered bus outputs; the request is latched once in
  // IDLE and held untouched until ack, so later cpu_* activity is ignored.
  always_comb begin
    state_d    = state_q;
    bus_cyc_d  = bus_cyc_q;
    bus_stb_d  = bus_stb_q;
    bus_we_d   = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_sel_d  = bus_sel_q;
    bus_data_d = bus_data_q;
    rd_buf_d   = rd_buf_q;
    case (state_q)
      IDLE: begin
        if (cpu_ce_i) begin
          bus_cyc_d  = 1'b1;
          bus_stb_d  = 1'b1;
          bus_we_d   = cpu_we_i;
          bus_addr_d = cpu_addr_i;
          bus_sel_d  = cpu_sel_i;
          bus_data_d = cpu_data_i;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          bus_cyc_d  = 1'b0;
          bus_stb_d  = 1'b0;
          bus_we_d   = 1'b0;
          bus_addr_d = '0;
          bus_sel_d  = '0;
          bus_data_d = '0;
          rd_buf_d   = bus_we_q ? '0 : bus_data_i;
          state_d    = (stall_i != 6'd0) ? WAIT_STALL : IDLE;
        end
      end
      WAIT_STALL: begin
        // Leaving here never starts a bus cycle: the request still on
        // cpu_ce_i is the one just completed.
        if (stall_i == 6'd0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        bus_cyc_d  = 1'b0;
        bus_stb_d  = 1'b0;
        bus_we_d   = 1'b0;
        bus_addr_d = '0;
        bus_sel_d  = '0;
        bus_data_d = '0;
      end
    endcase
  end

  // State and bus register update; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_cyc_q  <= 1'b0;
      bus_stb_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_sel_q  <= '0;
      bus_data_q <= '0;
      rd_buf_q   <= '0;
    end else begin
      state_q    <= state_d;
      bus_cyc_q  <= bus_cyc_d;
      bus_stb_q  <= bus_stb_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_sel_q  <= bus_sel_d;
      bus_data_q <= bus_data_d;
      rd_buf_q   <= rd_buf_d;
    end
  end

  // Pipeline-facing outputs: stall until the ack cycle, forward load data on
  // the ack cycle, then replay the buffered data while the pipeline is held.
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          stallreq_o = cpu_ce_i;
        end
        BUSY: begin
          if (bus_ack_i) begin
            cpu_data_o = bus_we_q ? '0 : bus_data_i;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        WAIT_STALL: begin
          cpu_data_o = rd_buf_q;
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

  assign bus_cyc_o  = bus_cyc_q;
  assign bus_stb_o  = bus_stb_q;
  assign bus_we_o   = bus_we_q;
  assign bus_addr_o = bus_addr_q;
  assign bus_sel_o  = bus_sel_q;
  assign bus_data_o = bus_data_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// Testbench for mem_bus_if: directed scenarios plus randomized transactions,
// each checked cycle by cycle against expectations derived from the
// transaction description (ack latency, stall length, load/store data).
module tb_mem_bus_if;

  logic        clk;
  logic        rst;
  logic [5:0]  stall_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  mem_bus_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_cyc_o  (bus_cyc_o),
    .bus_stb_o  (bus_stb_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_sel_o  (bus_sel_o),
    .bus_data_o (bus_data_o),
    .bus_data_i (bus_data_i),
    .bus_ack_i  (bus_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = '0; cpu_ce_i = 1'b1; cpu_we_i = 1'b1;
    cpu_addr_i = 32'hFFFF_FFFF; cpu_sel_i = 4'hF; cpu_data_i = 32'hFFFF_FFFF;
    bus_data_i = 32'hA5A5_A5A5; bus_ack_i = 1'b1;
    step(); step();
    #3;
    n_cmp++; if ({bus_cyc_o, bus_stb_o, bus_we_o} !== 3'b000) begin n_err++; $display("FAIL reset_ctl: got %b exp 000", {bus_cyc_o, bus_stb_o, bus_we_o}); end
    n_cmp++; if ({bus_addr_o, bus_sel_o, bus_data_o} !== 68'd0) begin n_err++; $display("FAIL reset_bus: got %h exp 0", {bus_addr_o, bus_sel_o, bus_data_o}); end
    n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stallreq: got %b exp 0", stallreq_o); end
    n_cmp++; if (cpu_data_o !== 32'd0) begin n_err++; $display("FAIL reset_cpu_data: got %h exp 0", cpu_data_o); end
    n_cmp++; if (dut.rd_buf_q !== 32'd0) begin n_err++; $display("FAIL reset_rd_buf: got %h exp 0", dut.rd_buf_q); end
    step();
    rst = 1'b0; cpu_ce_i = 1'b0; bus_ack_i = 1'b0;
    $display("txn reset: done");
  endtask

  // One full transaction starting from IDLE. n_ack = BUSY cycle carrying ack,
  // n_stall = number of WAIT_STALL cycles after completion (0 = none).
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int n_ack, input int n_stall,
                         input bit wiggle);
    logic [31:0] exp_ld;
    exp_ld = we ? 32'd0 : rdata;
    n_txn++;
    // IDLE cycle: request presented, pipeline must be stalled, no bus cycle yet.
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
    stall_i = '0; bus_ack_i = 1'b0; bus_data_i = $urandom;
    #3;
    n_cmp++; if ({bus_cyc_o, bus_stb_o} !== 2'b00) begin n_err++; $display("FAIL %s idle_cyc: got %b exp 00", name, {bus_cyc_o, bus_stb_o}); end
    n_cmp++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL %s idle_stallreq: got %b exp 1", name, stallreq_o); end
    n_cmp++; if (cpu_data_o !== 32'd0) begin n_err++; $display("FAIL %s idle_cpu_data: got %h exp 0", name, cpu_data_o); end
    step();
    for (int k = 1; k <= n_ack; k++) begin
      if (wiggle) begin
        cpu_ce_i = 1'($urandom); cpu_we_i = 1'($urandom); cpu_addr_i = $urandom;
        cpu_sel_i = 4'($urandom); cpu_data_i = $urandom;
      end
      bus_ack_i  = (k == n_ack);
      bus_data_i = (k == n_ack) ? rdata : $urandom;
      if (k < n_ack) stall_i = 6'($urandom_range(1, 63));
      else stall_i = (n_stall > 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      #3;
      n_cmp++; if ({bus_cyc_o, bus_stb_o} !== 2'b11) begin n_err++; $display("FAIL %s busy%0d_cyc: got %b exp 11", name, k, {bus_cyc_o, bus_stb_o}); end
      n_cmp++; if ({bus_we_o, bus_addr_o, bus_sel_o, bus_data_o} !== {we, addr, sel, wdata}) begin n_err++; $display("FAIL %s busy%0d_req: got %h exp %h", name, k, {bus_we_o, bus_addr_o, bus_sel_o, bus_data_o}, {we, addr, sel, wdata}); end
      n_cmp++; if (stallreq_o !== (k != n_ack)) begin n_err++; $display("FAIL %s busy%0d_stallreq: got %b exp %b", name, k, stallreq_o, (k != n_ack)); end
      n_cmp++; if (cpu_data_o !== ((k == n_ack) ? exp_ld : 32'd0)) begin n_err++; $display("FAIL %s busy%0d_cpu_data: got %h exp %h", name, k, cpu_data_o, ((k == n_ack) ? exp_ld : 32'd0)); end
      step();
    end
    // Pipeline held by another source: original request stays on cpu_*.
    for (int s = 1; s <= n_stall; s++) begin
      cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wdata;
      bus_ack_i = 1'b0; bus_data_i = $urandom;
      stall_i = (s < n_stall) ? 6'($urandom_range(1, 63)) : 6'd0;
      #3;
      n_cmp++; if ({bus_cyc_o, bus_stb_o} !== 2'b00) begin n_err++; $display("FAIL %s wait%0d_cyc: got %b exp 00", name, s, {bus_cyc_o, bus_stb_o}); end
      n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL %s wait%0d_stallreq: got %b exp 0", name, s, stallreq_o); end
      n_cmp++; if (cpu_data_o !== exp_ld) begin n_err++; $display("FAIL %s wait%0d_cpu_data: got %h exp %h", name, s, cpu_data_o, exp_ld); end
      step();
    end
    bus_ack_i = 1'b0; stall_i = '0; cpu_ce_i = 1'b0;
    $display("txn %0d %s: we=%0d addr=%h sel=%h wdata=%h rdata=%h ack@%0d wait=%0d",
             n_txn, name, we, addr, sel, wdata, rdata, n_ack, n_stall);
  endtask

  task automatic test_idle_after(input string name);
    #3;
    n_cmp++; if ({bus_cyc_o, bus_stb_o, bus_we_o} !== 3'b000) begin n_err++; $display("FAIL %s cyc_after: got %b exp 000", name, {bus_cyc_o, bus_stb_o, bus_we_o}); end
    n_cmp++; if ({stallreq_o, cpu_data_o} !== 33'd0) begin n_err++; $display("FAIL %s idle_out: got %h exp 0", name, {stallreq_o, cpu_data_o}); end
    step();
  endtask

  task automatic test_spurious_ack();
    cpu_ce_i = 1'b0; stall_i = '0;
    for (int i = 0; i < 3; i++) begin
      bus_ack_i = 1'b1; bus_data_i = $urandom;
      #3;
      n_cmp++; if ({bus_cyc_o, bus_stb_o, stallreq_o} !== 3'b000) begin n_err++; $display("FAIL spurious_ack%0d_ctl: got %b exp 000", i, {bus_cyc_o, bus_stb_o, stallreq_o}); end
      n_cmp++; if (cpu_data_o !== 32'd0) begin n_err++; $display("FAIL spurious_ack%0d_cpu_data: got %h exp 0", i, cpu_data_o); end
      step();
    end
    bus_ack_i = 1'b0;
    $display("txn spurious_ack: done");
    // Still in IDLE: a normal transaction must proceed with the usual timing.
    run_txn("after_spurious", 1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h1111_2222, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    // Leave a nonzero value in the read buffer first.
    run_txn("preload", 1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h7777_8888, 1, 1, 1'b0);
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0500; cpu_sel_i = 4'hC;
    cpu_data_i = 32'h5555_AAAA; bus_ack_i = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    #3;
    n_cmp++; if ({bus_cyc_o, bus_stb_o, bus_we_o} !== 3'b000) begin n_err++; $display("FAIL rst_mid_ctl: got %b exp 000", {bus_cyc_o, bus_stb_o, bus_we_o}); end
    n_cmp++; if (bus_addr_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_addr: got %h exp 0", bus_addr_o); end
    n_cmp++; if (dut.rd_buf_q !== 32'd0) begin n_err++; $display("FAIL rst_mid_rd_buf: got %h exp 0", dut.rd_buf_q); end
    n_cmp++; if ({stallreq_o, cpu_data_o} !== 33'd0) begin n_err++; $display("FAIL rst_mid_out: got %h exp 0", {stallreq_o, cpu_data_o}); end
    rst = 1'b0; cpu_ce_i = 1'b0;
    step();
    bus_ack_i = 1'b1; bus_data_i = 32'hBAD0_BAD0;
    #3;
    n_cmp++; if ({bus_cyc_o, stallreq_o} !== 2'b00) begin n_err++; $display("FAIL rst_mid_late_ack_ctl: got %b exp 00", {bus_cyc_o, stallreq_o}); end
    n_cmp++; if (cpu_data_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_late_ack_data: got %h exp 0", cpu_data_o); end
    step();
    bus_ack_i = 1'b0;
    $display("txn reset_mid: done");
  endtask

  task automatic test_random(input int count);
    for (int i = 0; i < count; i++) begin
      run_txn("random", 1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
              int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_idle_after("post_reset");
    run_txn("load_ack3", 1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 3, 0, 1'b0);
    test_idle_after("load_ack3");
    run_txn("store_ack1", 1'b1, 32'h0000_0204, 4'h3, 32'h1234_5678, 32'hFFFF_0000, 1, 0, 1'b0);
    test_idle_after("store_ack1");
    run_txn("load_wait_stall", 1'b0, 32'h0000_0208, 4'hF, 32'h0, 32'hCAFE_0001, 1, 2, 1'b0);
    test_idle_after("load_wait_stall");
    run_txn("addr_change", 1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'h0BAD_F00D, 4, 0, 1'b1);
    run_txn("back_to_back", 1'b1, 32'h0000_0404, 4'hF, 32'h9999_0000, 32'h0, 2, 1, 1'b1);
    test_spurious_ack();
    test_reset_mid();
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
